// File: rtl/i2c_rx_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_rx_sched_if
//  Description : Requester-side and engine-side signal bundle of i2c_rx_sched.
//  Revision    : 1.0  initial release
// ============================================================================
interface i2c_rx_sched_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    i_req;
    logic [16*NUM_REQ-1:0] i_add_sla;
    logic [2*NUM_REQ-1:0]  i_len_add;
    logic [3*NUM_REQ-1:0]  i_num_by;
    logic [NUM_REQ-1:0]    o_gnt;
    logic [NUM_REQ-1:0]    o_done;
    logic [63:0]           o_rdata;
    logic                  o_nack;
    logic                  o_err;
    logic                  o_timeout;
    logic                  o_m_en;
    logic                  o_m_start;
    logic [1:0]            o_m_len_add;
    logic [2:0]            o_m_num_by;
    logic [15:0]           o_m_add_sla;
    logic [4:0]            o_m_sem_lo;
    logic                  i_m_rs;
    logic                  i_m_err;
    logic                  i_m_detect;
    logic [63:0]           i_m_data;

    modport slave (
        input  i_req, i_add_sla, i_len_add, i_num_by,
        input  i_m_rs, i_m_err, i_m_detect, i_m_data,
        output o_gnt, o_done, o_rdata, o_nack, o_err, o_timeout,
        output o_m_en, o_m_start, o_m_len_add, o_m_num_by, o_m_add_sla, o_m_sem_lo
    );

    modport master (
        output i_req, i_add_sla, i_len_add, i_num_by,
        output i_m_rs, i_m_err, i_m_detect, i_m_data,
        input  o_gnt, o_done, o_rdata, o_nack, o_err, o_timeout,
        input  o_m_en, o_m_start, o_m_len_add, o_m_num_by, o_m_add_sla, o_m_sem_lo
    );
endinterface
`default_nettype wire

// File: rtl/i2c_rx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_rx_sched
//  Description : Round-robin scheduler sharing one I2C master-receive engine.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_rx_sched #(
    parameter int NUM_REQ = 2,
    parameter int SEM_LO  = 5,
    parameter int TIMEOUT = 65535
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    i2c_rx_sched_if.slave bus
);
    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_max = '1;
    localparam logic [c_ptr_w-1:0] c_last    = c_ptr_w'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LAUNCH, ST_WAIT_RS, ST_RELEASE, ST_ABORT, ST_DONE
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_ptr_w-1:0]   r_ptr, r_idx;
    logic [NUM_REQ-1:0]   r_gnt, r_done;
    logic [63:0]          r_rdata, r_cap;
    logic                 r_nack, r_err, r_timeout, r_cap_nack, r_sticky;
    logic                 r_m_en, r_m_start;
    logic [1:0]           r_m_len_add;
    logic [2:0]           r_m_num_by;
    logic [15:0]          r_m_add_sla;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [1:0]           r_rel_cnt;
    logic                 r_ab_cnt;

    logic                 w_any;
    logic [c_ptr_w-1:0]   w_pick;
    logic [NUM_REQ-1:0]   w_gnt_oh;
    logic [15:0]          w_sla;
    logic [1:0]           w_len;
    logic [2:0]           w_num;

    // Scan offsets from the pointer outward; the first requester hit wins.
    always_comb begin
        w_any    = 1'b0;
        w_pick   = '0;
        w_gnt_oh = '0;
        w_sla    = '0;
        w_len    = '0;
        w_num    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_any && bus.i_req[k] &&
                    ((int'(r_ptr) + i == k) || (int'(r_ptr) + i == k + NUM_REQ))) begin
                    w_any       = 1'b1;
                    w_pick      = c_ptr_w'(k);
                    w_gnt_oh[k] = 1'b1;
                    w_sla       = bus.i_add_sla[16*k +: 16];
                    w_len       = bus.i_len_add[2*k +: 2];
                    w_num       = bus.i_num_by[3*k +: 3];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_any) w_state_nxt = ST_LAUNCH;
            ST_LAUNCH:  w_state_nxt = ST_WAIT_RS;
            ST_WAIT_RS: begin
                if (bus.i_m_rs)              w_state_nxt = ST_RELEASE;
                else if (r_cnt == c_timeout) w_state_nxt = ST_ABORT;
            end
            ST_RELEASE: begin
                if (!bus.i_m_rs)             w_state_nxt = ST_DONE;
                else if (r_rel_cnt == 2'd3)  w_state_nxt = ST_ABORT;
            end
            ST_ABORT:   if (r_ab_cnt) w_state_nxt = ST_DONE;
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-state work first; state-entry actions below take precedence.
    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_ptr       <= '0;
            r_idx       <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_rdata     <= '0;
            r_cap       <= '0;
            r_nack      <= 1'b0;
            r_err       <= 1'b0;
            r_timeout   <= 1'b0;
            r_cap_nack  <= 1'b0;
            r_sticky    <= 1'b0;
            r_m_en      <= 1'b1;
            r_m_start   <= 1'b0;
            r_m_len_add <= '0;
            r_m_num_by  <= '0;
            r_m_add_sla <= '0;
            r_cnt       <= '0;
            r_rel_cnt   <= '0;
            r_ab_cnt    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_idx       <= w_pick;
                        r_gnt       <= w_gnt_oh;
                        r_m_add_sla <= w_sla;
                        r_m_len_add <= w_len;
                        r_m_num_by  <= w_num;
                    end
                end
                ST_LAUNCH: begin
                    r_m_start  <= 1'b1;
                    r_cnt      <= '0;
                    r_sticky   <= 1'b0;
                    r_cap      <= '0;
                    r_cap_nack <= 1'b0;
                end
                ST_WAIT_RS: begin
                    r_sticky <= r_sticky | bus.i_m_err;
                    if (r_cnt != c_cnt_max) r_cnt <= r_cnt + 1'b1;
                    if (bus.i_m_rs) begin
                        r_cap      <= bus.i_m_data;
                        r_cap_nack <= ~bus.i_m_detect;
                    end
                end
                ST_RELEASE: r_rel_cnt <= r_rel_cnt + 2'd1;
                ST_ABORT:   r_ab_cnt  <= 1'b1;
                ST_DONE: begin
                    r_done <= '0;
                    r_ptr  <= (r_idx == c_last) ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase

            if (w_state_nxt == ST_RELEASE && r_state != ST_RELEASE) begin
                r_m_start <= 1'b0;
                r_rel_cnt <= '0;
            end
            if (w_state_nxt == ST_ABORT && r_state != ST_ABORT) begin
                r_m_start <= 1'b0;
                r_m_en    <= 1'b0;
                r_ab_cnt  <= 1'b0;
            end
            // Results are published together so they stay coherent until the next done.
            if (w_state_nxt == ST_DONE && r_state != ST_DONE) begin
                r_m_en    <= 1'b1;
                r_done    <= r_gnt;
                r_gnt     <= '0;
                r_err     <= r_sticky;
                r_timeout <= (r_state == ST_ABORT);
                r_nack    <= (r_state == ST_ABORT) ? 1'b0 : r_cap_nack;
                r_rdata   <= (r_state == ST_ABORT) ? '0 : r_cap;
            end
        end
    end

    assign bus.o_gnt       = r_gnt;
    assign bus.o_done      = r_done;
    assign bus.o_rdata     = r_rdata;
    assign bus.o_nack      = r_nack;
    assign bus.o_err       = r_err;
    assign bus.o_timeout   = r_timeout;
    assign bus.o_m_en      = r_m_en;
    assign bus.o_m_start   = r_m_start;
    assign bus.o_m_len_add = r_m_len_add;
    assign bus.o_m_num_by  = r_m_num_by;
    assign bus.o_m_add_sla = r_m_add_sla;
    assign bus.o_m_sem_lo  = 5'(SEM_LO);
endmodule
`default_nettype wire

// File: tb/tb_i2c_rx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_rx_sched
//  Description : Directed scoreboard bench for i2c_rx_sched with an engine model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_rx_sched;
    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    i2c_rx_sched_if #(.NUM_REQ(2)) bus ();

    i2c_rx_sched #(.NUM_REQ(2), .SEM_LO(5), .TIMEOUT(100)) dut (
        .i_clk   (clk),
        .i_rst_n (rst),
        .bus     (bus)
    );

    typedef struct {
        int          idx;
        logic [63:0] rdata;
        logic        nack;
        logic        chk_nack;
        logic        err;
        logic        to;
    } exp_t;
    exp_t sb[$];

    logic        eng_respond;
    logic        eng_detect;
    logic        eng_err;
    int          eng_delay;
    logic [63:0] eng_data;
    int          eng_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [63:0] rd, input logic nk,
                        input logic chk_nk, input logic er, input logic to);
        exp_t e;
        e.idx = idx; e.rdata = rd; e.nack = nk; e.chk_nack = chk_nk; e.err = er; e.to = to;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (bus.o_done === 2'b00 && n < 300) begin
            tick();
            n++;
        end
        check(tag, 64'(|bus.o_done), 64'd1);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (bus.o_m_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(bus.o_m_start), 64'd1);
    endtask

    // Engine model: returns eng_data ^ address so every requester sees distinct data.
    initial begin
        bus.i_m_rs = 1'b0; bus.i_m_err = 1'b0; bus.i_m_detect = 1'b0; bus.i_m_data = '0;
        eng_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !bus.o_m_start) begin
                bus.i_m_rs  = 1'b0;
                bus.i_m_err = 1'b0;
                eng_cnt     = 0;
            end else begin
                eng_cnt++;
                bus.i_m_err = eng_err && (eng_cnt == 2);
                if (eng_respond && eng_cnt >= eng_delay) begin
                    bus.i_m_rs     = 1'b1;
                    bus.i_m_detect = eng_detect;
                    bus.i_m_data   = eng_data ^ {48'h0, bus.o_m_add_sla};
                end
            end
        end
    end

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && bus.o_done !== 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(bus.o_done), 64'd0);
            end else begin
                exp_t e;
                logic [1:0] oh;
                e  = sb.pop_front();
                oh = 2'b01 << e.idx;
                check("sb_done", 64'(bus.o_done), 64'(oh));
                check("sb_rdata", bus.o_rdata, e.rdata);
                check("sb_err", 64'(bus.o_err), 64'(e.err));
                check("sb_timeout", 64'(bus.o_timeout), 64'(e.to));
                if (e.chk_nack) check("sb_nack", 64'(bus.o_nack), 64'(e.nack));
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.i_req     = 2'b00;
        bus.i_add_sla = {16'h0068, 16'h0050};
        bus.i_len_add = {2'b01, 2'b00};
        bus.i_num_by  = {3'd4, 3'd2};
        eng_respond = 1'b1; eng_detect = 1'b1; eng_err = 1'b0; eng_delay = 3;
        eng_data    = 64'h0000_0000_0000_A50A;
        repeat (3) tick();

        check("rst_gnt", 64'(bus.o_gnt), 64'd0);
        check("rst_done", 64'(bus.o_done), 64'd0);
        check("rst_rdata", bus.o_rdata, 64'd0);
        check("rst_flags", 64'({bus.o_nack, bus.o_err, bus.o_timeout}), 64'd0);
        check("rst_en_start", 64'({bus.o_m_en, bus.o_m_start}), 64'b10);
        check("rst_fields", 64'({bus.o_m_len_add, bus.o_m_num_by, bus.o_m_add_sla}), 64'd0);
        check("rst_sem_lo", 64'(bus.o_m_sem_lo), 64'd5);
        rst = 1'b0;
        tick();

        // Single requester 0, address held then disturbed after grant
        push(0, 64'h0000_0000_0000_A55A, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.i_req = 2'b01;
        tick();
        check("t1_gnt", 64'(bus.o_gnt), 64'b01);
        check("t1_start_lat", 64'(bus.o_m_start), 64'd0);
        check("t1_fields", 64'({bus.o_m_len_add, bus.o_m_num_by, bus.o_m_add_sla}),
              64'({2'b00, 3'd2, 16'h0050}));
        tick();
        check("t1_start", 64'(bus.o_m_start), 64'd1);
        bus.i_add_sla[15:0] = 16'h1234;
        tick();
        check("t1_sla_hold", 64'(bus.o_m_add_sla), 64'h0050);
        wait_done("t1_done_seen");
        bus.i_req = 2'b00;
        bus.i_add_sla[15:0] = 16'h0050;
        tick();

        // Reset, then both requesters held: grants 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        eng_data = 64'h5A5A_0000_C3C3_0000;
        push(0, 64'h5A5A_0000_C3C3_0050, 1'b0, 1'b1, 1'b0, 1'b0);
        push(1, 64'h5A5A_0000_C3C3_0068, 1'b0, 1'b1, 1'b0, 1'b0);
        push(0, 64'h5A5A_0000_C3C3_0050, 1'b0, 1'b1, 1'b0, 1'b0);
        push(1, 64'h5A5A_0000_C3C3_0068, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.i_req = 2'b11;
        tick();
        check("t2_gnt_first", 64'(bus.o_gnt), 64'b01);
        for (int i = 0; i < 4; i++) begin
            wait_done("t2_done_seen");
            if (i == 3) bus.i_req = 2'b00;
            tick();
        end

        // Requester 1 alone: slave absent and an engine error pulse
        eng_detect = 1'b0; eng_err = 1'b1;
        eng_data   = 64'h0123_4567_89AB_CDEF;
        push(1, 64'h0123_4567_89AB_CD87, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.i_req = 2'b10;
        tick();
        check("t3_gnt", 64'(bus.o_gnt), 64'b10);
        wait_done("t3_done_seen");
        bus.i_req = 2'b00;
        tick();
        eng_detect = 1'b1; eng_err = 1'b0;

        // Engine silent: abort after TIMEOUT, enable low for two cycles
        eng_respond = 1'b0;
        push(0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.i_req = 2'b01;
        wait_start("t4_start_seen");
        begin
            int n = 0;
            while (bus.o_m_en === 1'b1 && n < 200) begin
                tick();
                n++;
            end
            check("t4_en_fall_cycles", 64'(n), 64'd101);
        end
        check("t4_start_low", 64'(bus.o_m_start), 64'd0);
        tick();
        check("t4_en_low2", 64'(bus.o_m_en), 64'd0);
        tick();
        check("t4_en_back", 64'(bus.o_m_en), 64'd1);
        wait_done("t4_done_seen");
        bus.i_req = 2'b00;
        tick();

        // Reset during WAIT_RS; pointer returns to 0 afterwards
        bus.i_req = 2'b11;
        tick();
        check("t5_gnt_pre", 64'(bus.o_gnt), 64'b10);
        wait_start("t5_start_seen");
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t5_rst_gnt", 64'(bus.o_gnt), 64'd0);
        check("t5_rst_en_start", 64'({bus.o_m_en, bus.o_m_start}), 64'b10);
        check("t5_rst_timeout", 64'(bus.o_timeout), 64'd0);
        check("t5_rst_sla", 64'(bus.o_m_add_sla), 64'd0);
        eng_respond = 1'b1;
        eng_data    = 64'hFEED_FACE_0000_1111;
        push(0, 64'hFEED_FACE_0000_1141, 1'b0, 1'b1, 1'b0, 1'b0);
        push(1, 64'hFEED_FACE_0000_1179, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("t5_gnt_post", 64'(bus.o_gnt), 64'b01);
        wait_done("t5_done0_seen");
        bus.i_req = 2'b10;
        tick();
        wait_done("t5_done1_seen");
        bus.i_req = 2'b00;
        repeat (3) tick();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/i2c_rx_sched.md
Name: i2c_rx_sched

Overview:
Arbitrates one shared I2C master-receive engine between NUM_REQ requesters, such as the CPU register interface and a sensor-polling engine. It selects a requester round-robin and loads that requester's slave address, address length and byte count onto the engine. It then drives the engine's enable/start handshake, captures the received data and status, and returns them to the winning requester with a one-cycle done pulse. It also enforces a transaction timeout by pulsing the engine's enable low.

Parameters:
NUM_REQ, 2, number of requesters (1..4)
SEM_LO, 5, sample-point value driven constantly to engine (1..9)
TIMEOUT, 65535, max cycles from start assertion to engine completion flag

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-high (asserted = 1, despite name)
i_req  in  NUM_REQ  per-requester level request; held until its o_done
i_add_sla  in  16*NUM_REQ  slave address, requester k at [16k+15:16k]
i_len_add  in  2*NUM_REQ  address length code per requester
i_num_by  in  3*NUM_REQ  byte count per requester (0 treated as 1 by engine)
o_gnt  out  NUM_REQ  one-hot, high while requester owns engine
o_done  out  NUM_REQ  one-cycle pulse, transaction finished for requester k
o_rdata  out  64  received data, valid from o_done until next o_done
o_nack  out  1  slave not detected, valid with o_done
o_err  out  1  engine error seen during transaction, valid with o_done
o_timeout  out  1  transaction aborted by timeout, valid with o_done
o_m_en  out  1  engine enable
o_m_start  out  1  engine start
o_m_len_add  out  2  to engine
o_m_num_by  out  3  to engine
o_m_add_sla  out  16  to engine
o_m_sem_lo  out  5  constant SEM_LO
i_m_rs  in  1  engine completion flag
i_m_err  in  1  engine error flag
i_m_detect  in  1  engine slave-detect flag
i_m_data  in  64  engine receive register

Behaviour:
- Reset values: o_gnt=0, o_done=0, o_rdata=0, o_nack/o_err/o_timeout=0, o_m_en=1, o_m_start=0, o_m_len_add=0, o_m_num_by=0, o_m_add_sla=0. Round-robin pointer = 0. State = IDLE.
- Reset mid-transaction aborts immediately; no o_done is issued.
- States and transitions:
  - IDLE: when any i_req bit is set, pick the first set bit at or after the pointer, wrapping around. Latch that requester's fields into o_m_*. Set o_gnt one-hot. Go to LAUNCH.
  - LAUNCH (1 cycle): o_m_start=1. Clear the cycle counter and the sticky error. Go to WAIT_RS.
  - WAIT_RS: hold o_m_start=1. Each cycle, OR i_m_err into the sticky error and increment the counter.
    - If i_m_rs=1: latch o_rdata=i_m_data and o_nack=~i_m_detect, then go to RELEASE.
    - Else if counter==TIMEOUT: go to ABORT.
  - RELEASE: o_m_start=0. Wait for i_m_rs=0, at most 4 cycles; if it does not fall within 4 cycles, go to ABORT. Otherwise go to DONE.
  - ABORT (2 cycles): o_m_start=0, o_m_en=0. Set o_timeout=1 and o_rdata=0. Go to DONE.
  - DONE (1 cycle): pulse o_done[k]; o_err=sticky error. Clear o_gnt. Set pointer=(k+1) mod NUM_REQ. Go to IDLE.
- Status flags o_nack, o_err and o_timeout update only at DONE and hold until the next DONE. o_timeout is cleared at a non-aborted DONE.
- Latency, uncontended request with a fast engine: i_req high → o_gnt high next cycle → o_m_start high the cycle after.
- Requester fields are sampled only in IDLE. Changes after grant are ignored.
- Dropping i_req after grant does not abort; the transaction completes and o_done is still pulsed.
- A new request arriving during a transaction waits. Simultaneous requests resolve strictly by pointer order.
- A requester still holding i_req at its DONE cycle is eligible again only after all other pending requesters (fairness).
- Timeout counter: clog2(TIMEOUT+1) bits, saturating; it never wraps.

Test Plan:
- Single requester 0: addr=16'h0050, len=00, num_by=2; engine model raises i_m_rs with data 64'h0000_0000_0000_A55A and detect=1 → o_gnt=01, start high through completion, o_done[0] pulse, o_rdata=64'hA55A, o_nack=0, o_err=0, o_timeout=0.
- Both requesters assert in the same cycle after reset → req0 served first, then req1. With both held continuously, the grant sequence is 0,1,0,1.
- Engine returns detect=0 → o_done pulses with o_nack=1. A pulse of i_m_err mid-transfer gives o_err=1 at DONE.
- Engine never raises i_m_rs with TIMEOUT=100 → o_m_start falls and o_m_en is low for 2 cycles starting 101 cycles after LAUNCH; o_done pulses with o_timeout=1 and o_rdata=0.
- Reset asserted during WAIT_RS → all outputs return to reset values asynchronously, with no o_done. After release, a pending request is re-arbitrated from pointer 0.
- Requester changes i_add_sla after grant → o_m_add_sla keeps the originally latched value until DONE.
